// File: rtl/hk_spi_pkg.sv
// Shared definitions for the housekeeping SPI engine.
// Holds the FSM state encoding and the default header/data/prescaler sizes.
package hk_spi_pkg;

  localparam int HK_H_LNG = 16;
  localparam int HK_L_LNG = 8;
  localparam int HK_PRESC = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HDR,
    ST_DATA,
    ST_HOLD
  } spi_state_t;

endpackage

// File: rtl/hk_spi_presc.sv
// Half-period prescaler: counts 0..PRESC while enabled, ticks at PRESC and wraps.
// Held at zero when disabled so every transaction starts on a full half period.
module hk_spi_presc
  import hk_spi_pkg::*;
#(
  parameter int PRESC = HK_PRESC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW  = (PRESC < 1) ? 1 : $clog2(PRESC + 1);
  localparam logic [CW-1:0] TOP = CW'(PRESC);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == TOP)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == TOP);

endmodule

// File: rtl/hk_spi_engine.sv
// SPI master for housekeeping registers: header phase, then a write or read data phase.
// SCK idles high; MOSI changes on falling SCK, MISO is sampled on rising SCK.
//
// state | meaning
// IDLE  | waiting for start, CS high
// SETUP | CS low, one half period before the first SCK edge
// HDR   | shifting out header bits
// DATA  | shifting out write data or capturing read data
// HOLD  | one half period with SCK high before CS is released
module hk_spi_engine
  import hk_spi_pkg::*;
#(
  parameter int H_LNG = HK_H_LNG,
  parameter int L_LNG = HK_L_LNG,
  parameter int PRESC = HK_PRESC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_start_i,
  input  logic [15:0] dat_wr_h_i,
  input  logic [15:0] dat_wr_l_i,
  output logic [15:0] dat_rd_l_o,
  output logic        sts_spi_busy_o,
  output logic        spi_cs_o,
  output logic        spi_clk_o,
  input  logic        spi_miso_i,
  output logic        spi_mosi_o,
  output logic        spi_mosi_t
);

  localparam logic [31:0] HDR_KEEP = ~(32'hFFFF_FFFF >> H_LNG);
  localparam logic [15:0] RD_MASK  = 16'hFFFF >> (16 - L_LNG);
  localparam logic [4:0]  H_LAST   = 5'(H_LNG - 1);
  localparam logic [4:0]  L_LAST   = 5'(L_LNG - 1);

  spi_state_t r_state;
  spi_state_t w_state_nxt;

  logic        w_tick;
  logic        w_sck_fall;
  logic        w_sck_rise;
  logic [15:0] w_dat_l_al;
  logic [31:0] w_tx_load;

  logic [31:0] r_tx;
  logic [15:0] r_rx;
  logic [4:0]  r_bit_cnt;
  logic        r_rd;
  logic        r_cs;
  logic        r_sck;
  logic        r_mosi;
  logic        r_mosi_t;
  logic        r_busy;
  logic [15:0] r_dat_rd;

  hk_spi_presc #(
    .PRESC(PRESC)
  ) u_presc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (r_state != ST_IDLE),
    .o_tick(w_tick)
  );

  // Header bits sit at the top of the frame, data bits follow directly below them.
  assign w_dat_l_al = dat_wr_l_i << (16 - L_LNG);
  assign w_tx_load  = ({dat_wr_h_i, 16'h0000} & HDR_KEEP) | ({w_dat_l_al, 16'h0000} >> H_LNG);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sck_fall  = 1'b0;
    w_sck_rise  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spi_start_i) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (w_tick) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (w_tick) begin
          if (r_sck) begin
            w_sck_fall = 1'b1;
          end else begin
            w_sck_rise = 1'b1;
            if (r_bit_cnt == H_LAST) w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_sck) begin
            w_sck_fall = 1'b1;
          end else begin
            w_sck_rise = 1'b1;
            if (r_bit_cnt == L_LAST) w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_rd      <= 1'b0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b1;
      r_mosi    <= 1'b0;
      r_mosi_t  <= 1'b1;
      r_busy    <= 1'b0;
      r_dat_rd  <= '0;
    end else begin
      if (r_state == ST_IDLE && spi_start_i) begin
        r_tx      <= w_tx_load;
        r_rd      <= dat_wr_h_i[15];
        r_rx      <= '0;
        r_bit_cnt <= '0;
        r_cs      <= 1'b0;
        r_busy    <= 1'b1;
        r_mosi    <= 1'b0;
        r_mosi_t  <= 1'b0;
      end
      if (w_sck_fall) begin
        r_sck <= 1'b0;
        r_tx  <= r_tx << 1;
        r_mosi <= (r_state == ST_DATA && r_rd) ? 1'b0 : r_tx[31];
      end
      if (w_sck_rise) begin
        r_sck     <= 1'b1;
        r_rx      <= {r_rx[14:0], spi_miso_i};
        r_bit_cnt <= (w_state_nxt != r_state) ? 5'd0 : r_bit_cnt + 5'd1;
      end
      // A read releases MOSI for the entire data phase.
      if (r_state == ST_HDR && w_state_nxt == ST_DATA && r_rd) begin
        r_mosi_t <= 1'b1;
        r_mosi   <= 1'b0;
      end
      if (r_state == ST_HOLD && w_tick) begin
        r_cs     <= 1'b1;
        r_busy   <= 1'b0;
        r_mosi_t <= 1'b1;
        r_mosi   <= 1'b0;
        if (r_rd) r_dat_rd <= r_rx & RD_MASK;
      end
    end
  end

  assign dat_rd_l_o     = r_dat_rd;
  assign sts_spi_busy_o = r_busy;
  assign spi_cs_o       = r_cs;
  assign spi_clk_o      = r_sck;
  assign spi_mosi_o     = r_mosi;
  assign spi_mosi_t     = r_mosi_t;

endmodule

// File: tb/tb_hk_spi_engine.sv
// Scoreboard bench for hk_spi_engine: stimulus pushes expected frames, a monitor checks each finished transaction.
module tb_hk_spi_engine;

  localparam int H   = 16;
  localparam int L   = 8;
  localparam int PR  = 3;
  localparam int NB  = H + L;
  localparam int DUR = (2 * (H + L) + 2) * (PR + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dat_h = '0;
  logic [15:0] dat_l = '0;
  logic [15:0] dat_rd;
  logic        busy, cs, sck, miso, mosi, mosi_t;

  hk_spi_engine #(.H_LNG(H), .L_LNG(L), .PRESC(PR)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_start_i   (start),
    .dat_wr_h_i    (dat_h),
    .dat_wr_l_i    (dat_l),
    .dat_rd_l_o    (dat_rd),
    .sts_spi_busy_o(busy),
    .spi_cs_o      (cs),
    .spi_clk_o     (sck),
    .spi_miso_i    (miso),
    .spi_mosi_o    (mosi),
    .spi_mosi_t    (mosi_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] mosi;
    logic [23:0] mt;
    logic [15:0] rd;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_push = 0;
  int          n_txn = 0;
  logic [15:0] m_rd = '0;
  logic [23:0] slave_pat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Slave model: presents the next pattern bit after every falling SCK.
  int sl_idx = 0;
  initial miso = 1'b0;
  always @(negedge sck or negedge cs) begin
    if (sck === 1'b1) begin
      sl_idx = 0;
    end else if (sl_idx < NB) begin
      miso = slave_pat[NB-1-sl_idx];
      sl_idx++;
    end
  end

  // Reference: MOSI carries the header then the write byte (zeros on a read).
  task automatic issue(input logic [15:0] h, input logic [15:0] d, input logic [23:0] pat, input int gap);
    exp_t e;
    slave_pat = pat;
    dat_h     = h;
    dat_l     = d;
    start     = 1'b1;
    e.mosi    = {h, (h[15] ? 8'h00 : d[7:0])};
    e.mt      = h[15] ? 24'h0000FF : 24'h000000;
    if (h[15]) m_rd = {8'h00, pat[7:0]};
    e.rd      = m_rd;
    e.gap     = gap;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("wait_busy_rise", 32'(busy), 32'd1);
    t = 0;
    while (busy !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk("wait_busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_cs"},     32'(cs),     32'd1);
    chk({tag, "_sck"},    32'(sck),    32'd1);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_mosi_t"}, 32'(mosi_t), 32'd1);
    chk({tag, "_mosi"},   32'(mosi),   32'd0);
    chk({tag, "_rd"},     32'(dat_rd), 32'd0);
  endtask

  // Monitor: collects one frame per busy window and checks it against the scoreboard.
  logic        in_txn = 1'b0;
  logic        prev_sck = 1'b1;
  logic        cs_bad;
  logic [23:0] mosi_bits, mt_bits;
  int          len, falls, gap = 1000, last_gap;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_txn = 1'b0;
      gap    = 1000;
    end else if (busy) begin
      if (!in_txn) begin
        in_txn    = 1'b1;
        len       = 0;
        falls     = 0;
        mosi_bits = '0;
        mt_bits   = '0;
        cs_bad    = 1'b0;
        last_gap  = gap;
      end
      len++;
      if (cs !== 1'b0) cs_bad = 1'b1;
      if (prev_sck === 1'b1 && sck === 1'b0) begin
        mosi_bits = {mosi_bits[22:0], mosi};
        mt_bits   = {mt_bits[22:0], mosi_t};
        falls++;
      end
    end else begin
      if (in_txn) begin
        in_txn = 1'b0;
        n_txn++;
        if (sb.size() == 0) begin
          chk("unexpected_txn", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("busy_len",   32'(len),       32'(DUR));
          chk("sck_falls",  32'(falls),     32'(NB));
          chk("mosi_seq",   32'(mosi_bits), 32'(e.mosi));
          chk("mosi_t_seq", 32'(mt_bits),   32'(e.mt));
          chk("rd_data",    32'(dat_rd),    32'(e.rd));
          chk("cs_low",     32'(cs_bad),    32'd0);
          chk("idle_pins",  32'({cs, sck, mosi_t, mosi}), 32'b1110);
          if (e.gap >= 0) chk("cs_gap", 32'(last_gap), 32'(e.gap));
        end
        gap = 0;
      end
      gap++;
    end
    prev_sck = sck;
  end

  initial begin
    #400000;
    $display("FAIL watchdog n_chk=%0d required=finish", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_pins("reset");

    // First start accepted on the first edge after reset release.
    rst = 1'b0;
    issue(16'h0012, 16'h00A5, 24'h123456, -1);
    @(posedge clk);
    #1 chk("start_after_rst", 32'(busy), 32'd1);
    @(negedge clk) start = 1'b0;
    wait_done();

    issue(16'h8001, 16'h0000, {16'hBEEF, 8'h3C}, -1);
    @(negedge clk) start = 1'b0;
    wait_done();

    for (int i = 0; i < 8; i++) begin
      issue(16'($urandom), 16'($urandom), 24'($urandom), -1);
      @(negedge clk) start = 1'b0;
      wait_done();
    end

    // Starts during an active transaction must be ignored.
    issue(16'h8A5A, 16'h1234, 24'hC3A5E1, -1);
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dat_h = 16'($urandom); dat_l = 16'($urandom);
    @(negedge clk) start = 1'b0;
    repeat (44) @(negedge clk);
    start = 1'b1; dat_h = 16'($urandom); dat_l = 16'($urandom);
    @(negedge clk) start = 1'b0;
    wait_done();

    // Start held high: back-to-back frames with a single idle cycle between them.
    issue(16'h9377, 16'h0000, 24'h5A5AC7, -1);
    for (int k = 0; k < 3; k++) begin
      wait_done();
      if (k < 2) issue(16'h9377, 16'h0000, 24'h5A5AC7, 1);
      else start = 1'b0;
    end
    start = 1'b0;

    // Reset in the middle of a read.
    issue(16'hC000, 16'h0000, 24'h00005A, -1);
    @(negedge clk) start = 1'b0;
    wait_done();
    issue(16'h8123, 16'h0000, 24'h0000E7, -1);
    @(negedge clk) start = 1'b0;
    repeat (96) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_pins("mid_reset");
    void'(sb.pop_back());
    n_push--;
    m_rd = '0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    issue(16'h0042, 16'h00C9, 24'h000000, -1);
    @(negedge clk) start = 1'b0;
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_empty",  32'(sb.size()), 32'd0);
    chk("txn_count", 32'(n_txn),     32'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hk_spi_engine.md
HK_SPI_ENGINE -- requirements
Module: hk_spi_engine

Interface
REQ-001 Parameter H_LNG, default 16, header bit count shifted MSB first; range 1..16.
REQ-002 Parameter L_LNG, default 8, data-phase bit count; range 1..16.
REQ-003 Parameter PRESC, default 255, half SCK period = PRESC+1 clk_i cycles.
REQ-004 clk_i  in  1  system clock; the block uses this single clock only.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 spi_start_i  in  1  one-cycle start request.
REQ-007 dat_wr_h_i  in  16  header word; bit 15 = 1 read, 0 write; bits [15:16-H_LNG] are sent.
REQ-008 dat_wr_l_i  in  16  write data; bits [L_LNG-1:0] are sent.
REQ-009 dat_rd_l_o  out  16  read result, right-aligned, zero-extended.
REQ-010 sts_spi_busy_o  out  1  transaction in progress.
REQ-011 spi_cs_o  out  1  chip select, active low.
REQ-012 spi_clk_o  out  1  SCK, idle high.
REQ-013 spi_miso_i  in  1  serial input.
REQ-014 spi_mosi_o  out  1  serial output.
REQ-015 spi_mosi_t  out  1  MOSI tristate, 1 = high-Z.

Function
REQ-016 States: IDLE, SETUP, HDR, DATA, HOLD.
REQ-017 Tick: a prescaler counts 0..PRESC while not IDLE; a tick occurs at PRESC, then the prescaler wraps to 0; prescaler held at 0 in IDLE.
REQ-018 IDLE with start=1: next edge latches dat_wr_h_i/dat_wr_l_i, cs_o=0, busy=1, mosi_t=0, state SETUP.
REQ-019 Start while busy is ignored, without queueing or error.
REQ-020 SETUP lasts one half period, then goes to HDR.
REQ-021 At each tick with sck=1 during HDR/DATA: sck goes to 0 and MOSI updates to the next bit (MSB first).
REQ-022 At each tick with sck=0 during HDR/DATA: sck goes to 1, MISO is sampled into the shift register, and the bit counter increments.
REQ-023 After the H_LNG-th rising edge, HDR goes to DATA.
REQ-024 DATA, read (latched bit 15 = 1): mosi_t=1 and mosi_o=0 for the whole phase.
REQ-025 DATA, write: mosi_t=0 and dat_wr_l bits are driven.
REQ-026 After the L_LNG-th DATA rising edge, the block goes to HOLD; HOLD lasts one half period with sck=1.
REQ-027 HOLD exit, on the same edge: state IDLE, cs_o=1, busy=0, mosi_t=1, mosi_o=0.
REQ-028 HOLD exit, read only: dat_rd_l_o takes the L_LNG captured bits.
REQ-029 A write transaction leaves dat_rd_l_o unchanged.
REQ-030 Duration from start edge to busy low = (2*(H_LNG+L_LNG)+2)*(PRESC+1) cycles.
REQ-031 Start asserted in the same cycle busy falls is accepted; the next transaction begins with a fresh SETUP.
REQ-032 Inputs dat_wr_* may change during busy without effect.

Reset
REQ-033 rst_i asserted, at any time including mid-transaction: immediately IDLE, spi_cs_o=1, spi_clk_o=1, spi_mosi_t=1, spi_mosi_o=0, sts_spi_busy_o=0, dat_rd_l_o=0, counters and shift registers 0.
REQ-034 After rst_i deassertion, the first start is accepted on the first clk_i edge.

Structure
REQ-035 Package hk_spi_pkg holds the state enum and the default constants H_LNG/L_LNG/PRESC.
REQ-036 One sub-module, hk_spi_presc (prescaler plus tick output), is instantiated once; all remaining logic is in hk_spi_engine.
REQ-037 All outputs are registered; there is no combinational path from input to output.

Verification (PRESC=3, H_LNG=16, L_LNG=8)
REQ-038 Write: start, wr_h=16'h0012, wr_l=16'h00A5 -> 24 SCK falling edges; MOSI=0x0012 then 0xA5; mosi_t=0 throughout; busy high exactly 200 cycles; dat_rd_l_o unchanged.
REQ-039 Read: start, wr_h=16'h8001, slave drives 0x3C on MISO at rising edges -> mosi_t=1 during the last 8 bits; dat_rd_l_o=16'h003C when busy falls.
REQ-040 Start pulses at cycles 5 and 50 of an active transaction -> ignored; exactly one 200-cycle transaction occurs.
REQ-041 rst_i asserted at cycle 97 of a read -> same cycle: cs=1, sck=1, busy=0, dat_rd_l_o=0; a following write completes normally.
REQ-042 Start held high continuously -> back-to-back transactions; cs high for exactly one clk_i cycle between them; each lasts 200 cycles.
